pll_reset_seq: RTL and testbench
================================

# pll_reset_seq

Reset and lock supervisor for the system PLL: drives the PLL's active-high reset, watches its asynchronous lock output, and releases the system reset only after lock has been continuously stable. It runs on the 27 MHz board oscillator, because the PLL output is not trustworthy before lock. `sys_resetn` feeds the PicoRV core reset synchronizer. Loss of lock during operation re-enters the sequence and is counted.

## Interface
- `PLL_RST_CYCLES`, default 16: number of cycles `pll_reset` is held high per attempt (must be ≥1).
- `LOCK_STABLE_CYCLES`, default 1024: number of consecutive synchronized lock-high cycles required before system reset is released.
- `LOCK_TIMEOUT_CYCLES`, default 65536: number of cycles to wait for lock before retrying (used only with `PLLRSTSEQ_TIMEOUT_EN`).
- `clkin`  in  1  27 MHz reference clock; the only clock.
- `resetn`  in  1  Asynchronous, active-low reset.
- `pll_lock`  in  1  PLL lock; asynchronous to `clkin`.
- `soft_rst_req`  in  1  Synchronous single-cycle request to re-reset the system without resetting the PLL.
- `pll_reset`  out  1  Active-high reset to the PLL.
- `sys_resetn`  out  1  Active-low system reset.
- `locked`  out  1  High while in RUN.
- `relock_count`  out  8  Number of lock losses seen in RUN; saturates at 255.
- `timeout_flag`  out  1  Sticky; set on any lock timeout.

## Operation
- Lock input passes through a 2-flop synchronizer to give `lock_s`. Only `lock_s` is used.
- Counters are sized with `$clog2` of the largest parameter plus 1. All outputs are registered.
- States:
  - PLLRST: `pll_reset`=1, `sys_resetn`=0. Count `PLL_RST_CYCLES`, then go to WAITLOCK with the counter cleared.
  - WAITLOCK: `pll_reset`=0, `sys_resetn`=0. If `lock_s`=1, go to STABLE. If timeout is enabled and `LOCK_TIMEOUT_CYCLES` elapse, set `timeout_flag` and go to PLLRST.
  - STABLE: `sys_resetn`=0. The counter increments on each `lock_s`=1 cycle. On `lock_s`=0, go to WAITLOCK with the counter cleared. When the count reaches `LOCK_STABLE_CYCLES`, go to RUN.
  - RUN: `sys_resetn`=1, `locked`=1. On `lock_s`=0, go to PLLRST and increment `relock_count` (saturating). Otherwise, `soft_rst_req`=1 sends the block to STABLE with the counter cleared.
- If `lock_s`=0 and `soft_rst_req`=1 arrive in the same cycle in RUN, lock loss wins: go to PLLRST and increment the count.
- `soft_rst_req` is ignored outside RUN.
- `resetn` asserted in any state immediately forces the reset state. `relock_count` and `timeout_flag` clear only on `resetn`.

## Timing
- Reset values: state=PLLRST, `pll_reset`=1, `sys_resetn`=0, `locked`=0, `relock_count`=0, `timeout_flag`=0, counters=0.
- `pll_reset` falls on the `PLL_RST_CYCLES`-th rising edge after `resetn` deasserts.
- Lock-to-`lock_s` latency is 2 cycles.
- `sys_resetn` and `locked` rise together, registered, on the edge after the `LOCK_STABLE_CYCLES`-th consecutive `lock_s`=1 sample.
- From `pll_lock` falling in RUN:
  - `sys_resetn`/`locked` fall 3 edges later (2 sync + 1 register).
  - `pll_reset` rises on that same edge.
- `soft_rst_req` in RUN drops `sys_resetn` on the next edge.
- Timeout counting starts from the first WAITLOCK cycle.

## Configuration
- `PLLRSTSEQ_TIMEOUT_EN` defined: the WAITLOCK timeout and retry are active, and `timeout_flag` can set.
- Not defined: WAITLOCK waits indefinitely, `timeout_flag` is tied to 0, and the timeout counter is not built.

## Test plan
All scenarios use `PLL_RST_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32.
- **Clean start:** release `resetn`, raise `pll_lock` at cycle 10 → `pll_reset` low at edge 4, `sys_resetn`/`locked` high at cycle 10+2+8+1=21, `relock_count`=0.
- **Lock glitch during STABLE:** drop `pll_lock` for 3 cycles after 5 stable cycles → `sys_resetn` stays 0 and stable counting restarts. Release comes 8 `lock_s`-high cycles after lock returns.
- **Lock loss in RUN:** drop `pll_lock` → 3 edges later `sys_resetn`=0 and `pll_reset`=1 for 4 cycles, `relock_count`=1. Repeat 300 times → count saturates at 255.
- **Timeout (macro on):** hold `pll_lock`=0 → `pll_reset` re-pulses every 4+32 cycles, `timeout_flag`=1 stays set after lock succeeds. With the macro off, `pll_reset` pulses once only and `timeout_flag`=0.
- **Soft reset:** pulse `soft_rst_req` in RUN → `sys_resetn`=0 for 9 cycles, `pll_reset` stays 0. Pulse it in the same cycle as a lock drop → PLLRST is taken and `relock_count` increments.
- **Async reset mid-STABLE:** assert `resetn` → outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pll_reset_seq.sv
// -----------------------------------------------------------------------------
// pll_reset_seq
//
// Reset and lock supervisor for the system PLL. Runs on the 27 MHz board
// oscillator because the PLL output cannot be trusted before it locks. The
// block holds the PLL in reset for a fixed number of cycles and then waits for
// lock. Lock must stay continuously high for a programmable number of cycles
// before the system reset is released. A loss of lock while running restarts
// the sequence and is counted.
//
// Ports:
//   clkin         in   27 MHz reference clock (the only clock)
//   resetn        in   asynchronous active-low reset
//   pll_lock      in   PLL lock indication, asynchronous to clkin
//   soft_rst_req  in   single-cycle request to re-reset the system only
//   pll_reset     out  active-high PLL reset
//   sys_resetn    out  active-low system reset (to the core reset synchronizer)
//   locked        out  high while the system is running
//   relock_count  out  lock losses seen while running, saturates at 255
//   timeout_flag  out  sticky, set on any lock timeout
//
// Configuration macro:
//   PLLRSTSEQ_TIMEOUT_EN  when defined, WAITLOCK gives up after
//                         LOCK_TIMEOUT_CYCLES and re-pulses the PLL reset.
//                         When undefined, WAITLOCK waits forever, the timeout
//                         counter is not built and timeout_flag is tied to 0.
// -----------------------------------------------------------------------------
module pll_reset_seq #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic       clkin,
  input  logic       resetn,
  input  logic       pll_lock,
  input  logic       soft_rst_req,
  output logic       pll_reset,
  output logic       sys_resetn,
  output logic       locked,
  output logic [7:0] relock_count,
  output logic       timeout_flag
);

  localparam int unsigned MAX_RS  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                    PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_RS > LOCK_TIMEOUT_CYCLES) ?
                                    MAX_RS : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_ALL) + 1;

  // PLLRST leaves on its last cycle so pll_reset falls on the N-th edge.
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  // STABLE leaves one edge after the N-th good sample has been counted.
  localparam logic [CNT_W-1:0] STABLE_DONE = CNT_W'(LOCK_STABLE_CYCLES);

  typedef enum logic [1:0] {
    ST_PLLRST   = 2'd0,
    ST_WAITLOCK = 2'd1,
    ST_STABLE   = 2'd2,
    ST_RUN      = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       relock_q, relock_d;
  logic             pll_reset_q, pll_reset_d;
  logic             sys_resetn_q, sys_resetn_d;
  logic             locked_q, locked_d;
  logic             lock_meta_q, lock_s_q;
  logic             timeout_hit;

  // Two-flop synchronizer for the asynchronous lock; only lock_s_q is used.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here make lock_s_q take the previous
      // lock_meta_q, giving two real flops; blocking would collapse the chain.
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

`ifdef PLLRSTSEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             timeout_q, timeout_d;

  // Counts only while waiting without lock; any other state holds it at zero,
  // so counting restarts from the first WAITLOCK cycle of every attempt.
  assign timeout_hit = (state_q == ST_WAITLOCK) && !lock_s_q && (to_cnt_q == TO_LAST);

  always_comb begin
    to_cnt_d  = '0;
    timeout_d = timeout_q;
    if (timeout_hit) begin
      timeout_d = 1'b1;
    end else if ((state_q == ST_WAITLOCK) && !lock_s_q) begin
      to_cnt_d = to_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_flag = timeout_q;
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    relock_d = relock_q;

    case (state_q)
      ST_PLLRST: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAITLOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAITLOCK: begin
        if (lock_s_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = ST_PLLRST;
          cnt_d   = '0;
        end
      end

      ST_STABLE: begin
        if (cnt_q == STABLE_DONE) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (!lock_s_q) begin
          state_d = ST_WAITLOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        // Lock loss outranks a simultaneous soft reset request.
        if (!lock_s_q) begin
          state_d = ST_PLLRST;
          cnt_d   = '0;
          if (relock_q != 8'hFF) begin
            relock_d = relock_q + 8'd1;
          end
        end else if (soft_rst_req) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_PLLRST;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register together with it.
  assign pll_reset_d  = (state_d == ST_PLLRST);
  assign sys_resetn_d = (state_d == ST_RUN);
  assign locked_d     = (state_d == ST_RUN);

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_PLLRST;
      cnt_q        <= '0;
      relock_q     <= '0;
      pll_reset_q  <= 1'b1;
      sys_resetn_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      relock_q     <= relock_d;
      pll_reset_q  <= pll_reset_d;
      sys_resetn_q <= sys_resetn_d;
      locked_q     <= locked_d;
    end
  end

  assign pll_reset    = pll_reset_q;
  assign sys_resetn   = sys_resetn_q;
  assign locked       = locked_q;
  assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_seq
//
// Directed bench for pll_reset_seq with PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8,
// LOCK_TIMEOUT_CYCLES=32. Stimulus pushes hand-computed expected output
// snapshots, tagged with the clock edge they belong to, into a scoreboard; an
// independent monitor samples the outputs 1 ns after every edge (or at once on
// request, for the asynchronous reset check) and compares matching entries.
// Direct point checks go through check().
// Edge numbers below count rising edges after resetn is released.
// -----------------------------------------------------------------------------
module tb_pll_reset_seq;

`ifdef PLLRSTSEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       resetn;
  logic       pll_lock;
  logic       soft_rst_req;
  logic       pll_reset;
  logic       sys_resetn;
  logic       locked;
  logic [7:0] relock_count;
  logic       timeout_flag;

  pll_reset_seq #(
    .PLL_RST_CYCLES     (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32)
  ) dut (
    .clkin        (clk),
    .resetn       (resetn),
    .pll_lock     (pll_lock),
    .soft_rst_req (soft_rst_req),
    .pll_reset    (pll_reset),
    .sys_resetn   (sys_resetn),
    .locked       (locked),
    .relock_count (relock_count),
    .timeout_flag (timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    string name;
    bit    pr;
    bit    sr;
    int    rc;
    bit    tf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  event chk_now;

  task automatic check(input string nm, input logic [7:0] got,
                       input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, got, want);
    end
  endtask

  // Expected snapshot: pll_reset, sys_resetn (locked must equal it),
  // relock_count and timeout_flag.
  function automatic void exp_at(input int c, input string nm, input bit pr,
                                 input bit sr, input int rc, input bit tf);
    exp_t e;
    e.cyc  = c;
    e.name = nm;
    e.pr   = pr;
    e.sr   = sr;
    e.rc   = rc;
    e.tf   = tf;
    sb.push_back(e);
  endfunction

  task automatic exp_now(input string nm, input bit pr, input bit sr,
                         input int rc, input bit tf);
    exp_at(cyc, nm, pr, sr, rc, tf);
    -> chk_now;
  endtask

  // Monitor: compare every scoreboard entry due at the current edge count.
  always begin
    @(posedge clk or chk_now);
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        total++;
        if (pll_reset !== sb[i].pr || sys_resetn !== sb[i].sr ||
            locked !== sb[i].sr || relock_count !== 8'(sb[i].rc) ||
            timeout_flag !== sb[i].tf) begin
          bad++;
          $display("FAIL %s cyc=%0d got pr=%b sr=%b lk=%b rc=%0d tf=%b want pr=%b sr=%b lk=%b rc=%0d tf=%b",
                   sb[i].name, cyc, pll_reset, sys_resetn, locked, relock_count,
                   timeout_flag, sb[i].pr, sb[i].sr, sb[i].sr, sb[i].rc, sb[i].tf);
        end
        sb.delete(i);
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Request sampled by edge s.
  task automatic pulse_soft(input int s);
    wait_cyc(s - 1);
    soft_rst_req = 1'b1;
    wait_cyc(s);
    soft_rst_req = 1'b0;
  endtask

  // pll_lock first sampled low at edge l; RUN sees lock_s=0 at l+2.
  // Lock returns (sampled at l+3); WAITLOCK from l+6, STABLE at l+7, RUN at l+16.
  task automatic lock_loss(input int l, input int n, input bit detail);
    int rc_now;
    int rc_prev;
    rc_now  = (n > 255) ? 255 : n;
    rc_prev = ((n - 1) > 255) ? 255 : (n - 1);
    if (detail) begin
      exp_at(l + 1,  "loss_still_run",  1'b0, 1'b1, rc_prev, 1'b0);
      exp_at(l + 5,  "loss_rst_hold",   1'b1, 1'b0, rc_now,  1'b0);
      exp_at(l + 6,  "loss_rst_fall",   1'b0, 1'b0, rc_now,  1'b0);
      exp_at(l + 15, "loss_pre_relock", 1'b0, 1'b0, rc_now,  1'b0);
    end
    exp_at(l + 2,  "loss_drop",   1'b1, 1'b0, rc_now, 1'b0);
    exp_at(l + 16, "loss_relock", 1'b0, 1'b1, rc_now, 1'b0);
    wait_cyc(l - 1);
    pll_lock = 1'b0;
    wait_cyc(l + 2);
    pll_lock = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int b, s, g, l, x, y, t;
    resetn       = 1'b0;
    pll_lock     = 1'b0;
    soft_rst_req = 1'b0;
    repeat (3) @(negedge clk);
    exp_now("reset_state", 1'b1, 1'b0, 0, 1'b0);
    #1;
    check("init_pll_reset",  8'(pll_reset),  8'd1);
    check("init_sys_resetn", 8'(sys_resetn), 8'd0);
    check("init_relock",     relock_count,   8'd0);
    #1;
    resetn = 1'b1;
    b = cyc;

    // Clean start: lock sampled at edge 10, release at edge 21.
    exp_at(b + 3,  "rst_hold",    1'b1, 1'b0, 0, 1'b0);
    exp_at(b + 4,  "rst_fall",    1'b0, 1'b0, 0, 1'b0);
    exp_at(b + 12, "waitlock",    1'b0, 1'b0, 0, 1'b0);
    exp_at(b + 20, "pre_release", 1'b0, 1'b0, 0, 1'b0);
    exp_at(b + 21, "release",     1'b0, 1'b1, 0, 1'b0);
    wait_cyc(b + 9);
    pll_lock = 1'b1;

    // Soft reset in RUN: sys_resetn low for 9 cycles, PLL untouched.
    s = b + 25;
    exp_at(s - 1, "run_pre_soft", 1'b0, 1'b1, 0, 1'b0);
    exp_at(s,     "soft_drop",    1'b0, 1'b0, 0, 1'b0);
    exp_at(s + 4, "soft_mid",     1'b0, 1'b0, 0, 1'b0);
    exp_at(s + 8, "soft_last",    1'b0, 1'b0, 0, 1'b0);
    exp_at(s + 9, "soft_release", 1'b0, 1'b1, 0, 1'b0);
    pulse_soft(s);

    // Glitch in STABLE: 5 good samples, then lock low for 3 cycles.
    g = s + 12;
    exp_at(g,      "glitch_enter",    1'b0, 1'b0, 0, 1'b0);
    exp_at(g + 9,  "glitch_no_early", 1'b0, 1'b0, 0, 1'b0);
    exp_at(g + 17, "glitch_last",     1'b0, 1'b0, 0, 1'b0);
    exp_at(g + 18, "glitch_release",  1'b0, 1'b1, 0, 1'b0);
    pulse_soft(g);
    wait_cyc(g + 3);
    pll_lock = 1'b0;
    wait_cyc(g + 6);
    pll_lock = 1'b1;

    // First lock loss in RUN.
    l = g + 22;
    lock_loss(l, 1, 1'b1);

    // Lock drop and soft request seen in the same cycle: lock loss wins.
    // A soft request during PLLRST is ignored.
    x = l + 20;
    exp_at(x - 1,  "both_pre",     1'b0, 1'b1, 1, 1'b0);
    exp_at(x,      "both_drop",    1'b1, 1'b0, 2, 1'b0);
    exp_at(x + 3,  "both_pllrst",  1'b1, 1'b0, 2, 1'b0);
    exp_at(x + 4,  "both_rst_fall",1'b0, 1'b0, 2, 1'b0);
    exp_at(x + 13, "both_pre_run", 1'b0, 1'b0, 2, 1'b0);
    exp_at(x + 14, "both_relock",  1'b0, 1'b1, 2, 1'b0);
    wait_cyc(x - 3);
    pll_lock = 1'b0;
    wait_cyc(x - 1);
    soft_rst_req = 1'b1;
    wait_cyc(x);
    soft_rst_req = 1'b0;
    wait_cyc(x + 1);
    pll_lock     = 1'b1;
    soft_rst_req = 1'b1;
    wait_cyc(x + 2);
    soft_rst_req = 1'b0;

    // Repeated lock losses up to 300: count saturates at 255.
    l = x + 18;
    for (int n = 3; n <= 300; n++) begin
      lock_loss(l, n, (n == 255) || (n == 256) || (n == 300));
      l = l + 18;
    end

    // Asynchronous reset in the middle of STABLE.
    y = l;
    exp_at(y + 3, "stable_before_rst", 1'b0, 1'b0, 255, 1'b0);
    pulse_soft(y);
    wait_cyc(y + 3);
    resetn   = 1'b0;
    pll_lock = 1'b0;
    exp_now("async_rst", 1'b1, 1'b0, 0, 1'b0);
    #1;
    check("async_pll_reset",  8'(pll_reset),  8'd1);
    check("async_sys_resetn", 8'(sys_resetn), 8'd0);
    check("async_locked",     8'(locked),     8'd0);
    check("async_relock",     relock_count,   8'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    t = cyc;

    // No lock: with the timeout the PLL is re-pulsed every 4+32 cycles.
    exp_at(t + 4,  "to_first_fall",  1'b0,  1'b0, 0, 1'b0);
    exp_at(t + 35, "to_before",      1'b0,  1'b0, 0, 1'b0);
    exp_at(t + 36, "to_retry",       TO_EN, 1'b0, 0, TO_EN);
    exp_at(t + 39, "to_retry_hold",  TO_EN, 1'b0, 0, TO_EN);
    exp_at(t + 40, "to_retry_fall",  1'b0,  1'b0, 0, TO_EN);
    exp_at(t + 72, "to_retry2",      TO_EN, 1'b0, 0, TO_EN);
    exp_at(t + 90, "to_pre_release", 1'b0,  1'b0, 0, TO_EN);
    exp_at(t + 91, "to_release",     1'b0,  1'b1, 0, TO_EN);
    wait_cyc(t + 79);
    pll_lock = 1'b1;

    wait_cyc(t + 95);
    #2;
    check("final_sys_resetn", 8'(sys_resetn),   8'd1);
    check("final_locked",     8'(locked),       8'd1);
    check("final_relock",     relock_count,     8'd0);
    check("final_timeout",    8'(timeout_flag), 8'(TO_EN));
    foreach (sb[i]) begin
      total++;
      bad++;
      $display("FAIL missed %s due_cyc=%0d now=%0d", sb[i].name, sb[i].cyc, cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
